// File: rtl/anneal_pkg.sv
// Shared types and default sizing for the anneal sequencer and its timer.
package anneal_pkg;

  localparam int SWEEP_W_DEF     = 16;
  localparam int GAP_W_DEF       = 8;
  localparam int TIMEOUT_CYC_DEF = 1023;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRE,
    ST_WAIT_NET,
    ST_MU,
    ST_GAP,
    ST_READ,
    ST_DONE
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/anneal_sequencer_cycle_timer.sv
// Loadable down-counter shared by the inter-sweep gap and the network-wait watchdog.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/anneal_sequencer.sv
// Sweep sequencer for the annealing neuron array: fire, settle, mu update, gap, readout.
// Define ANNEAL_SEQ_WATCHDOG_EN to build in the WAIT_NET watchdog and the timeout flag.
//
// state    | meaning
// IDLE     | waiting for start, config not yet latched
// FIRE     | one-cycle fire strobe to the neuron array
// WAIT_NET | waiting for the spike network to settle
// MU       | one-cycle mu-update strobe
// GAP      | idle gap of gap_cycles+1 cycles after a sweep
// READ     | readout requested, waiting for read_done
// DONE     | one-cycle run-complete pulse
module anneal_sequencer
  import anneal_pkg::*;
#(
  parameter int SWEEP_W     = SWEEP_W_DEF,
  parameter int GAP_W       = GAP_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [SWEEP_W-1:0] num_sweeps,
  input  logic [SWEEP_W-1:0] mu_period,
  input  logic [GAP_W-1:0]   gap_cycles,
  input  logic               network_done,
  input  logic               read_done,
  output logic               fire_pulse,
  output logic               mu_pulse,
  output logic               rd,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int TMR_W = max_int(GAP_W, WD_W);

  state_e             state_q, state_d;
  logic [SWEEP_W-1:0] num_q, mu_per_q, sweep_q, mu_cnt_q, mu_next;
  logic [GAP_W-1:0]   gap_q;
  logic               fire_q, mu_q, rd_q, busy_q, done_q;
  logic               latch, sweep_inc, mu_hit;
  logic               tmr_load, tmr_en, tmr_expired;
  logic [TMR_W-1:0]   tmr_val;
`ifdef ANNEAL_SEQ_WATCHDOG_EN
  logic               wd_trip;
  logic               timeout_q;
`endif

  // mu_cnt_q tracks sweeps since the last mu update, so the modulo test is a compare.
  assign mu_next = mu_cnt_q + 1'b1;
  assign mu_hit  = (mu_per_q != '0) && (mu_next == mu_per_q);

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    sweep_inc = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_val   = '0;
`ifdef ANNEAL_SEQ_WATCHDOG_EN
    wd_trip   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          latch   = 1'b1;
          state_d = (num_sweeps == '0) ? ST_DONE : ST_FIRE;
        end
      end
      ST_FIRE: begin
        state_d = ST_WAIT_NET;
`ifdef ANNEAL_SEQ_WATCHDOG_EN
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(TIMEOUT_CYC - 1);
`endif
      end
      ST_WAIT_NET: begin
        if (network_done) begin
          sweep_inc = 1'b1;
          if (mu_hit) begin
            state_d = ST_MU;
          end else begin
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(gap_q);
          end
`ifdef ANNEAL_SEQ_WATCHDOG_EN
        end else if (tmr_expired) begin
          wd_trip = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmr_en = 1'b1;
`endif
        end
      end
      ST_MU: begin
        state_d  = ST_GAP;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(gap_q);
      end
      ST_GAP: begin
        if (tmr_expired) begin
          state_d = (sweep_q == num_q) ? ST_READ : ST_FIRE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_READ: begin
        if (read_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d   = ST_IDLE;
      latch     = 1'b0;
      sweep_inc = 1'b0;
      tmr_load  = 1'b0;
      tmr_en    = 1'b0;
`ifdef ANNEAL_SEQ_WATCHDOG_EN
      wd_trip   = 1'b0;
`endif
    end
  end

  // Outputs are decoded from the next state so every strobe is registered yet lines up with its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      num_q    <= '0;
      mu_per_q <= '0;
      gap_q    <= '0;
      sweep_q  <= '0;
      mu_cnt_q <= '0;
      fire_q   <= 1'b0;
      mu_q     <= 1'b0;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fire_q  <= (state_d == ST_FIRE);
      mu_q    <= (state_d == ST_MU);
      rd_q    <= (state_d == ST_READ);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      if (latch) begin
        num_q    <= num_sweeps;
        mu_per_q <= mu_period;
        gap_q    <= gap_cycles;
        sweep_q  <= '0;
        mu_cnt_q <= '0;
      end else if (sweep_inc) begin
        sweep_q  <= sweep_q + 1'b1;
        mu_cnt_q <= mu_hit ? '0 : mu_next;
      end
    end
  end

`ifdef ANNEAL_SEQ_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else if (latch) begin
      timeout_q <= 1'b0;
    end else if (wd_trip) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  cycle_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .enable   (tmr_en),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  assign fire_pulse = fire_q;
  assign mu_pulse   = mu_q;
  assign rd         = rd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sweep_cnt  = sweep_q;

endmodule

// File: tb/tb_anneal_sequencer.sv
// Self-checking bench for anneal_sequencer: timeline model compared every cycle plus directed literal checks.
// "network_done D cycles after fire" means D idle cycles between the fire cycle and the network_done cycle.
module tb_anneal_sequencer;

  localparam int SW = 16;
  localparam int GW = 8;
  localparam int TO = 16;
`ifdef ANNEAL_SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [SW-1:0] num_sweeps, mu_period;
  logic [GW-1:0] gap_cycles;
  logic          network_done, read_done;
  logic          fire_pulse, mu_pulse, rd, busy, done, timeout;
  logic [SW-1:0] sweep_cnt;

  logic nd_resp = 1'b0, nd_spur = 1'b0, rd_resp = 1'b0, rd_spur = 1'b0;
  assign network_done = nd_resp | nd_spur;
  assign read_done    = rd_resp | rd_spur;

  anneal_sequencer #(.SWEEP_W(SW), .GAP_W(GW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_sweeps(num_sweeps), .mu_period(mu_period), .gap_cycles(gap_cycles),
    .network_done(network_done), .read_done(read_done),
    .fire_pulse(fire_pulse), .mu_pulse(mu_pulse), .rd(rd), .busy(busy),
    .done(done), .timeout(timeout), .sweep_cnt(sweep_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- timeline model ----------------
  logic          m_fire = 0, m_mu = 0, m_rd = 0, m_busy = 0, m_done = 0, m_to = 0;
  logic [SW-1:0] m_sweep = '0;

  task automatic step(output bit k);
    @(posedge clk);
    k = reset || abort;
    if (k) begin
      m_fire = 0; m_mu = 0; m_rd = 0; m_done = 0; m_busy = 0;
      if (reset) begin
        m_sweep = '0;
        m_to    = 0;
      end
    end
  endtask

  task automatic model_run(input int n, input int mp, input int g);
    bit k;
    int waited;
    m_sweep = '0; m_to = 0; m_busy = 1;
    if (n == 0) begin
      m_done = 1;
      step(k); if (k) return;
      m_done = 0; m_busy = 0;
      return;
    end
    forever begin
      m_fire = 1;
      step(k); if (k) return;
      m_fire = 0;
      waited = 0;
      forever begin
        step(k); if (k) return;
        if (network_done) break;
        waited++;
        if (WD && waited == TO) begin
          m_to = 1; m_done = 1;
          step(k); if (k) return;
          m_done = 0; m_busy = 0;
          return;
        end
      end
      m_sweep = m_sweep + 1'b1;
      if (mp != 0 && (int'(m_sweep) % mp) == 0) begin
        m_mu = 1;
        step(k); if (k) return;
        m_mu = 0;
      end
      for (int i = 0; i <= g; i++) begin
        step(k); if (k) return;
      end
      if (int'(m_sweep) == n) break;
    end
    m_rd = 1;
    forever begin
      step(k); if (k) return;
      if (read_done) break;
    end
    m_rd = 0; m_done = 1;
    step(k); if (k) return;
    m_done = 0; m_busy = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_sweep = '0;
        m_to    = 0;
      end else if (start && !abort) begin
        model_run(int'(num_sweeps), int'(mu_period), int'(gap_cycles));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("fire_pulse", fire_pulse, m_fire);
      check("mu_pulse", mu_pulse, m_mu);
      check("rd", rd, m_rd);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("timeout", timeout, m_to);
      check("sweep_cnt", sweep_cnt, m_sweep);
    end
  end

  // ---------------- responders and monitors ----------------
  bit nd_en = 0;
  int nd_delay = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (fire_pulse && nd_en) begin
        repeat (nd_delay + 1) @(negedge clk);
        nd_resp = 1'b1;
        @(negedge clk);
        nd_resp = 1'b0;
      end
    end
  end

  int rd_wait = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rd) begin
        rd_wait++;
        rd_resp = (rd_wait == 3);
      end else begin
        rd_wait = 0;
        rd_resp = 1'b0;
      end
    end
  end

  int fire_q[$];
  int mus = 0, rds = 0, dones = 0, done_cyc = 0, mu_at_sweep = 0;
  always @(negedge clk) begin
    if (fire_pulse) fire_q.push_back(cyc);
    if (mu_pulse) begin
      mus++;
      mu_at_sweep = int'(sweep_cnt);
    end
    if (rd) rds++;
    if (done) begin
      dones++;
      done_cyc = cyc;
    end
  end

  // ---------------- stimulus ----------------
  int start_cyc;
  int f0, mu0, rd0, d0;

  task automatic snap();
    f0 = fire_q.size(); mu0 = mus; rd0 = rds; d0 = dones;
  endtask

  task automatic kick(input int n, input int mp, input int g);
    num_sweeps = SW'(n); mu_period = SW'(mp); gap_cycles = GW'(g);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    for (i = 0; i < budget && busy; i++) @(negedge clk);
    check(name, busy, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit: got running, want finished");
    $fatal(1);
  end

  initial begin
    int nf, i;
    reset = 1; start = 0; abort = 0;
    num_sweeps = '0; mu_period = '0; gap_cycles = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("rst_busy", busy, 0);
    check("rst_sweep", sweep_cnt, 0);
    check("rst_timeout", timeout, 0);
    reset = 0;
    @(negedge clk);

    // 3 sweeps, mu every 2, gap 4, network settles 5 cycles after each fire
    nd_en = 1; nd_delay = 5; snap();
    kick(3, 2, 4);
    wait_idle("t1_idle", 200);
    check("t1_fires", fire_q.size() - f0, 3);
    if (fire_q.size() >= f0 + 3) begin
      check("t1_first_fire_lat", fire_q[f0] - start_cyc, 1);
      check("t1_spacing_12", fire_q[f0+1] - fire_q[f0], 12);
      check("t1_spacing_23_mu", fire_q[f0+2] - fire_q[f0+1], 13);
    end
    check("t1_mu_count", mus - mu0, 1);
    check("t1_mu_after_sweep", mu_at_sweep, 2);
    check("t1_rd_cycles", rds - rd0, 3);
    check("t1_done_count", dones - d0, 1);
    check("t1_sweep_cnt", sweep_cnt, 3);

    // zero sweeps: straight to done
    snap();
    kick(0, 1, 1);
    wait_idle("t2_idle", 10);
    check("t2_done_count", dones - d0, 1);
    check("t2_done_lat", done_cyc - start_cyc, 1);
    check("t2_fires", fire_q.size() - f0, 0);
    check("t2_rd", rds - rd0, 0);

    // no gap, no mu, fast network
    nd_delay = 1; snap();
    kick(2, 0, 0);
    wait_idle("t3_idle", 100);
    check("t3_fires", fire_q.size() - f0, 2);
    if (fire_q.size() >= f0 + 2) check("t3_spacing", fire_q[f0+1] - fire_q[f0], 4);
    check("t3_mu", mus - mu0, 0);
    check("t3_sweep_cnt", sweep_cnt, 2);

    // abort in the 4th WAIT_NET
    nd_delay = 5; snap();
    kick(10, 3, 1);
    nf = 0; i = 0;
    while (nf < 4 && i < 400) begin
      if (fire_pulse) nf++;
      if (nf < 4) begin
        @(negedge clk);
        i++;
      end
    end
    check("t4_reached_4th_fire", nf, 4);
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("t4_busy_after_abort", busy, 0);
    check("t4_sweep_cnt", sweep_cnt, 3);
    check("t4_no_done", dones - d0, 0);
    repeat (10) @(negedge clk);

    // start while busy, config change, spurious read_done/network_done in FIRE
    nd_delay = 2; snap();
    kick(2, 1, 1);
    rd_spur = 1; nd_spur = 1; start = 1;
    num_sweeps = 7; mu_period = 0; gap_cycles = 9;
    @(negedge clk);
    rd_spur = 0; nd_spur = 0;
    repeat (3) @(negedge clk);
    start = 0;
    wait_idle("t5_idle", 100);
    check("t5_fires", fire_q.size() - f0, 2);
    if (fire_q.size() >= f0 + 2) check("t5_spacing", fire_q[f0+1] - fire_q[f0], 7);
    check("t5_mu_count", mus - mu0, 2);
    check("t5_done_count", dones - d0, 1);
    check("t5_sweep_cnt", sweep_cnt, 2);

    // reset during READ
    nd_delay = 2; snap();
    kick(1, 0, 0);
    i = 0;
    while (!rd && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("t6_reached_read", rd, 1);
    reset = 1;
    @(negedge clk);
    check("t6_rd_cleared", rd, 0);
    check("t6_busy", busy, 0);
    check("t6_sweep_cleared", sweep_cnt, 0);
    reset = 0;
    repeat (5) @(negedge clk);
    check("t6_no_done", dones - d0, 0);

    // network never settles
    nd_en = 0; snap();
    kick(2, 0, 0);
`ifdef ANNEAL_SEQ_WATCHDOG_EN
    wait_idle("t7_idle", 60);
    check("t7_timeout", timeout, 1);
    check("t7_done_count", dones - d0, 1);
    check("t7_fires", fire_q.size() - f0, 1);
    if (fire_q.size() >= f0 + 1) check("t7_done_lat", done_cyc - fire_q[f0], 17);
    check("t7_rd", rds - rd0, 0);
    nd_en = 1; nd_delay = 1;
    kick(1, 0, 0);
    check("t7_timeout_cleared", timeout, 0);
    wait_idle("t7b_idle", 60);
`else
    repeat (40) @(negedge clk);
    check("t7_still_busy", busy, 1);
    check("t7_no_timeout", timeout, 0);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("t7_abort_idle", busy, 0);
    nd_en = 1;
`endif

    // start and abort together in IDLE
    snap();
    num_sweeps = 3; start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    check("t8_abort_wins", busy, 0);
    repeat (5) @(negedge clk);
    check("t8_no_fire", fire_q.size() - f0, 0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
